// File: rtl/prm_chk_scan_if.sv
// Bus bundle for prm_chk_scan: mask write port, query handshake and result handshake.
// The master modport belongs to the query source and result consumer; the slave modport belongs to the checker.
interface prm_chk_scan_if #(
    parameter int XW    = 3,
    parameter int YW    = 3,
    parameter int ZW    = 3,
    parameter int NPAGE = 8,
    parameter int DW    = 32
);
    localparam int MW = 1 << (XW + YW + ZW);
    localparam int NW = MW / DW;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int PW = $clog2(NPAGE);
    localparam int CW = $clog2(NPAGE + 1);

    logic             wr_en;
    logic [PW-1:0]    wr_page;
    logic [WW-1:0]    wr_word;
    logic [DW-1:0]    wr_data;

    logic             q_valid;
    logic             q_ready;
    logic [XW-1:0]    q_x;
    logic [YW-1:0]    q_y;
    logic [ZW-1:0]    q_z;
    logic [NPAGE-1:0] q_pmask;

    logic             r_valid;
    logic             r_ready;
    logic [NPAGE-1:0] r_hits;
    logic [CW-1:0]    r_count;
    logic             r_any;
    logic [PW-1:0]    r_first;

    modport master (
        output wr_en, wr_page, wr_word, wr_data,
        output q_valid, q_x, q_y, q_z, q_pmask,
        input  q_ready,
        input  r_valid, r_hits, r_count, r_any, r_first,
        output r_ready
    );

    modport slave (
        input  wr_en, wr_page, wr_word, wr_data,
        input  q_valid, q_x, q_y, q_z, q_pmask,
        output q_ready,
        output r_valid, r_hits, r_count, r_any, r_first,
        input  r_ready
    );
endinterface

// File: rtl/prm_chk_scan.sv
// Loadable NPAGE-page edge-mask checker that scans one enabled page per cycle for each {x,y,z} query.
// Define PRM_CHK_EARLY_EXIT_EN to stop the scan at the first enabled page that hits.
module prm_chk_scan #(
    parameter int XW    = 3,
    parameter int YW    = 3,
    parameter int ZW    = 3,
    parameter int NPAGE = 8,
    parameter int DW    = 32
) (
    input logic           CLK,
    input logic           RST,
    prm_chk_scan_if.slave bus
);
    localparam int IW = XW + YW + ZW;
    localparam int MW = 1 << IW;
    localparam int NW = MW / DW;
    localparam int PW = $clog2(NPAGE);
    localparam int CW = $clog2(NPAGE + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic [NW-1:0][DW-1:0] mask [NPAGE];

    state_t           state;
    logic [IW-1:0]    idx_q;
    logic [NPAGE-1:0] pmask_q;
    logic [NPAGE-1:0] hit_acc;
    logic [PW-1:0]    ptr;

    logic             q_ready_r;
    logic             r_valid_r;
    logic [NPAGE-1:0] r_hits_r;
    logic [CW-1:0]    r_count_r;
    logic             r_any_r;
    logic [PW-1:0]    r_first_r;

    logic [MW-1:0]    page_bits;
    logic             page_hit;
    logic [NPAGE-1:0] hit_next;
    logic             scan_end;

    function automatic logic [CW-1:0] popcount(input logic [NPAGE-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NPAGE; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    function automatic logic [PW-1:0] lowest_set(input logic [NPAGE-1:0] v);
        logic [PW-1:0] f;
        f = '0;
        for (int i = NPAGE - 1; i >= 0; i--) if (v[i]) f = PW'(i);
        return f;
    endfunction

    // The mask register is read before any same-edge write lands, so the page under scan sees the old word.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        page_bits = mask[ptr];
        page_hit  = pmask_q[ptr] & page_bits[idx_q];
        hit_next  = hit_acc;
        hit_next[ptr] = page_hit;
        scan_end  = (ptr == PW'(NPAGE - 1));
`ifdef PRM_CHK_EARLY_EXIT_EN
        scan_end  = scan_end | page_hit;
`endif
    end

    // NOTE: the mask bank is reset because a query after reset must see every page empty; this forces flops, not RAM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int p = 0; p < NPAGE; p++) mask[p] <= '0;
        end else if (bus.wr_en && (int'(bus.wr_page) < NPAGE)) begin
            mask[bus.wr_page][bus.wr_word] <= bus.wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            idx_q     <= '0;
            pmask_q   <= '0;
            hit_acc   <= '0;
            ptr       <= '0;
            q_ready_r <= 1'b1;
            r_valid_r <= 1'b0;
            r_hits_r  <= '0;
            r_count_r <= '0;
            r_any_r   <= 1'b0;
            r_first_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.q_valid) begin
                        idx_q     <= {bus.q_x, bus.q_y, bus.q_z};
                        pmask_q   <= bus.q_pmask;
                        hit_acc   <= '0;
                        ptr       <= '0;
                        q_ready_r <= 1'b0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    hit_acc <= hit_next;
                    ptr     <= ptr + 1'b1;
                    if (scan_end) begin
                        state     <= DONE;
                        r_valid_r <= 1'b1;
                        r_hits_r  <= hit_next;
                        r_count_r <= popcount(hit_next);
                        r_any_r   <= |hit_next;
                        r_first_r <= lowest_set(hit_next);
                    end
                end
                DONE: begin
                    // No bypass to a new accept here: q_ready only returns once back in IDLE.
                    if (bus.r_ready) begin
                        state     <= IDLE;
                        r_valid_r <= 1'b0;
                        q_ready_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.q_ready = q_ready_r;
    assign bus.r_valid = r_valid_r;
    assign bus.r_hits  = r_hits_r;
    assign bus.r_count = r_count_r;
    assign bus.r_any   = r_any_r;
    assign bus.r_first = r_first_r;
endmodule

// File: tb/tb_prm_chk_scan.sv
// Directed bench for prm_chk_scan: a mask model feeds a scoreboard queue, popped when r_valid rises.
// Build with PRM_CHK_EARLY_EXIT_EN defined to check the early-exit variant.
module tb_prm_chk_scan;
    localparam int NPAGE = 8;

    typedef struct {
        logic [7:0] hits;
        logic [3:0] count;
        logic       any;
        logic [2:0] first;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prm_chk_scan_if #(.XW(3), .YW(3), .ZW(3), .NPAGE(NPAGE), .DW(32)) bus ();

    prm_chk_scan #(.XW(3), .YW(3), .ZW(3), .NPAGE(NPAGE), .DW(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    logic [511:0] model [NPAGE];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model_expect(input logic [8:0] idx, input logic [7:0] pm);
        exp_t e;
        e.hits = '0; e.count = '0; e.any = 1'b0; e.first = '0; e.lat = NPAGE;
        for (int p = 0; p < NPAGE; p++) begin
            if (pm[p] && model[p][idx]) begin
`ifdef PRM_CHK_EARLY_EXIT_EN
                if (!e.any) begin
                    e.hits[p] = 1'b1; e.count = 4'd1; e.any = 1'b1;
                    e.first = 3'(p); e.lat = p + 1;
                end
`else
                if (!e.any) e.first = 3'(p);
                e.hits[p] = 1'b1;
                e.any     = 1'b1;
                e.count   = e.count + 4'd1;
`endif
            end
        end
        return e;
    endfunction

    task automatic do_write(input int p, input int w, input logic [31:0] d);
        @(negedge clk);
        bus.wr_en = 1'b1; bus.wr_page = 3'(p); bus.wr_word = 4'(w); bus.wr_data = d;
        @(negedge clk);
        bus.wr_en = 1'b0;
        model[p][w*32 +: 32] = d;
    endtask

    // wr_at = k puts a write on the k-th edge after accept; page p is evaluated on edge p+1.
    task automatic run_query(input string tag, input logic [2:0] x, input logic [2:0] y,
                             input logic [2:0] z, input logic [7:0] pm, input int hold,
                             input int wr_at, input int wp, input int ww, input logic [31:0] wd);
        exp_t e;
        int   lat;
        bit   got;
        @(negedge clk);
        check({tag, ".q_ready_idle"}, 64'(bus.q_ready), 64'd1);
        bus.q_x = x; bus.q_y = y; bus.q_z = z; bus.q_pmask = pm; bus.q_valid = 1'b1;
        sb.push_back(model_expect({x, y, z}, pm));
        @(posedge clk);
        @(negedge clk);
        bus.q_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (wr_at == lat + 1) begin
                bus.wr_en = 1'b1; bus.wr_page = 3'(wp); bus.wr_word = 4'(ww); bus.wr_data = wd;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.wr_en = 1'b0;
            if (bus.r_valid) got = 1'b1;
        end
        if (wr_at != 0) model[wp][ww*32 +: 32] = wd;
        check({tag, ".r_valid_seen"}, 64'(got), 64'd1);
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".latency"}, 64'(lat),        64'(e.lat));
            check({tag, ".r_hits"},  64'(bus.r_hits),  64'(e.hits));
            check({tag, ".r_count"}, 64'(bus.r_count), 64'(e.count));
            check({tag, ".r_any"},   64'(bus.r_any),   64'(e.any));
            check({tag, ".r_first"}, 64'(bus.r_first), 64'(e.first));
            check({tag, ".q_ready_done"}, 64'(bus.q_ready), 64'd0);
            for (int i = 0; i < hold; i++) begin
                bus.q_valid = 1'b1; bus.q_x = ~x; bus.q_pmask = ~pm;
                @(posedge clk);
                @(negedge clk);
                check({tag, ".hold_valid"},   64'(bus.r_valid), 64'd1);
                check({tag, ".hold_hits"},    64'(bus.r_hits),  64'(e.hits));
                check({tag, ".hold_first"},   64'(bus.r_first), 64'(e.first));
                check({tag, ".hold_q_ready"}, 64'(bus.q_ready), 64'd0);
            end
            bus.q_valid = 1'b0;
            bus.r_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.r_ready = 1'b0;
            check({tag, ".r_valid_drop"},  64'(bus.r_valid), 64'd0);
            check({tag, ".q_ready_after"}, 64'(bus.q_ready), 64'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_valid;
        for (int p = 0; p < NPAGE; p++) model[p] = '0;
        bus.wr_en = 1'b0; bus.wr_page = '0; bus.wr_word = '0; bus.wr_data = '0;
        bus.q_valid = 1'b0; bus.q_x = '0; bus.q_y = '0; bus.q_z = '0; bus.q_pmask = '0;
        bus.r_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.q_ready", 64'(bus.q_ready), 64'd1);
        check("reset.r_valid", 64'(bus.r_valid), 64'd0);
        check("reset.r_hits",  64'(bus.r_hits),  64'd0);
        check("reset.r_count", 64'(bus.r_count), 64'd0);
        check("reset.r_any",   64'(bus.r_any),   64'd0);
        check("reset.r_first", 64'(bus.r_first), 64'd0);

        do_write(3, 0, 32'h0000_0001);
        run_query("t1_p3_idx0", 3'd0, 3'd0, 3'd0, 8'hFF, 0, 0, 0, 0, '0);

        do_write(1, 15, 32'h8000_0000);
        do_write(4, 15, 32'h8000_0000);
        do_write(7, 15, 32'h8000_0000);
        run_query("t2_idx511", 3'd7, 3'd7, 3'd7, 8'hEF, 0, 0, 0, 0, '0);
        run_query("t3_hold", 3'd7, 3'd7, 3'd7, 8'hEF, 5, 0, 0, 0, '0);
        run_query("pmask_zero", 3'd7, 3'd7, 3'd7, 8'h00, 0, 0, 0, 0, '0);
        run_query("last_page", 3'd7, 3'd7, 3'd7, 8'h80, 0, 0, 0, 0, '0);
        run_query("miss", 3'd4, 3'd0, 3'd0, 8'hFF, 0, 0, 0, 0, '0);

        // idx 156 = word 4, bit 28
        run_query("wr_same_cycle", 3'd2, 3'd3, 3'd4, 8'hFF, 0, 6, 5, 4, 32'h1000_0000);
        do_write(5, 4, 32'h0);
        model[5][156] = 1'b1;
        run_query("wr_two_early", 3'd2, 3'd3, 3'd4, 8'hFF, 0, 4, 5, 4, 32'h1000_0000);

        // Reset during scan: accept, then assert RST while page 3 is under evaluation.
        @(negedge clk);
        bus.q_x = 3'd7; bus.q_y = 3'd7; bus.q_z = 3'd7; bus.q_pmask = 8'hFF; bus.q_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.q_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midscan_rst.r_valid", 64'(bus.r_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < NPAGE; p++) model[p] = '0;
        @(negedge clk);
        check("midscan_rst.q_ready", 64'(bus.q_ready), 64'd1);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.r_valid) seen_valid = 1'b1;
        end
        check("midscan_rst.no_result", 64'(seen_valid), 64'd0);
        run_query("post_rst_idx511", 3'd7, 3'd7, 3'd7, 8'hFF, 0, 0, 0, 0, '0);
        run_query("post_rst_idx0", 3'd0, 3'd0, 3'd0, 8'hFF, 0, 0, 0, 0, '0);
        run_query("post_rst_idx156", 3'd2, 3'd3, 3'd4, 8'hFF, 0, 0, 0, 0, '0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
